multi_mode_timer: RTL and testbench

MULTI_MODE_TIMER -- requirements
Module: multi_mode_timer

---
 rtl/timer_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 26 ++
 rtl/multi_mode_timer.sv | 247 ++++++++++++++++++++++++
 tb/tb_multi_mode_timer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-mode timer: FSM state encoding,
// button indices and 7-segment digit patterns ({g..a}, active-high).
package timer_pkg;

  typedef enum logic [2:0] {
    SW_STOP = 3'd0,
    SW_RUN  = 3'd1,
    TM_STOP = 3'd2,
    TM_RUN  = 3'd3,
    TM_DONE = 3'd4,
    SET     = 3'd5
  } state_e;

  localparam int BTN_MODE  = 0;
  localparam int BTN_START = 1;
  localparam int BTN_SET   = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 4;
  localparam int NUM_BTN   = 5;

  localparam logic [2:0] LED_STOPWATCH = 3'b001;
  localparam logic [2:0] LED_TIMER     = 3'b010;
  localparam logic [2:0] LED_SET       = 3'b100;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to 7-segment pattern, segments ordered {g,f,e,d,c,b,a}.
module seg7_decode
  import timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_mode_timer.sv
// Stopwatch / countdown timer / preset editor with BCD count, debounced-free
// button edge events and a registered multiplexed-free 7-segment output.
module multi_mode_timer
  import timer_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 25_000_000,
  parameter int SEG_INV   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode_btn,
  input  logic                  start_btn,
  input  logic                  set_btn,
  input  logic                  up_btn,
  input  logic                  down_btn,
  output logic [7*DIGITS-1:0]   seg,
  output logic [2:0]            led_mode,
  output logic                  led_run,
  output logic                  led_done
);

  localparam int NW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] CUR_LAST   = CW'(DIGITS - 1);
  localparam logic          INV_BIT    = (SEG_INV != 0);
  localparam logic [SW-1:0] SEG_RST    = {DIGITS{SEG_0}} ^ {SW{INV_BIT}};

  function automatic logic [NW-1:0] bcd_inc(input logic [NW-1:0] v);
    logic [NW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] bcd_dec(input logic [NW-1:0] v);
    logic [NW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [NW-1:0]          count_q, count_d;
  logic [NW-1:0]          preset_q, preset_d;
  logic [CW-1:0]          cursor_q, cursor_d;
  logic [TW-1:0]          presc_q, presc_d;
  logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   blink_q, blink_d;
  logic [NUM_BTN-1:0]     sync1_q, sync1_d;
  logic [NUM_BTN-1:0]     sync2_q, sync2_d;
  logic [NUM_BTN-1:0]     sync3_q, sync3_d;
  logic [SW-1:0]          seg_q, seg_d;
  logic [2:0]             led_mode_q, led_mode_d;
  logic                   led_run_q, led_run_d;
  logic                   led_done_q, led_done_d;

  logic [NUM_BTN-1:0]     evt;
  logic                   ev_mode, ev_start, ev_set, ev_up, ev_down;
  logic                   in_run, tick;
  logic [NW-1:0]          disp;
  logic [SW-1:0]          dec_raw;

  // Synchroniser and edge detect; the event is the first cycle sync2 sees high
  always_comb begin
    sync1_d  = {down_btn, up_btn, set_btn, start_btn, mode_btn};
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    evt      = sync2_q & ~sync3_q;
    ev_mode  = evt[BTN_MODE];
    ev_start = evt[BTN_START] & ~evt[BTN_MODE];
    ev_set   = evt[BTN_SET]   & ~(|evt[BTN_START:BTN_MODE]);
    ev_up    = evt[BTN_UP]    & ~(|evt[BTN_SET:BTN_MODE]);
    ev_down  = evt[BTN_DOWN]  & ~(|evt[BTN_UP:BTN_MODE]);
  end

  assign in_run = (state_q == SW_RUN) || (state_q == TM_RUN);
  assign tick   = in_run && (presc_q == TICK_LAST);

  // Tick updates the count first; events may then override the state
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    cursor_d = cursor_q;

    if (tick && state_q == SW_RUN) begin
      count_d = bcd_inc(count_q);
    end else if (tick && state_q == TM_RUN) begin
      count_d = bcd_dec(count_q);
      if (count_d == '0) state_d = TM_DONE;
    end

    case (state_q)
      SW_STOP: begin
        if (ev_mode)       state_d = TM_STOP;
        else if (ev_start) state_d = SW_RUN;
        else if (ev_down)  count_d = '0;
      end
      SW_RUN: begin
        if (ev_start) state_d = SW_STOP;
      end
      TM_STOP: begin
        if (ev_mode)                        state_d = SET;
        else if (ev_start && count_q != '0) state_d = TM_RUN;
      end
      TM_RUN: begin
        if (ev_start) state_d = TM_STOP;
      end
      TM_DONE: begin
        if (|evt) state_d = TM_STOP;
      end
      SET: begin
        if (ev_mode) begin
          state_d = SW_STOP;
        end else if (ev_set) begin
          cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + CW'(1);
        end else if (ev_up || ev_down) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cursor_q == CW'(i)) begin
              if (ev_up)
                preset_d[4*i +: 4] = (preset_q[4*i +: 4] == 4'd9) ? 4'd0 : preset_q[4*i +: 4] + 4'd1;
              else
                preset_d[4*i +: 4] = (preset_q[4*i +: 4] == 4'd0) ? 4'd9 : preset_q[4*i +: 4] - 4'd1;
            end
          end
        end
      end
      default: state_d = SW_STOP;
    endcase

    if (state_d == TM_STOP && state_q != TM_STOP) count_d  = preset_q;
    if (state_d == SET && state_q != SET)         cursor_d = '0;
  end

  // Prescaler and blink counter restart on every entry to their states
  always_comb begin
    presc_d     = '0;
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if ((state_d == SW_RUN || state_d == TM_RUN) && state_d == state_q)
      presc_d = tick ? '0 : presc_q + TW'(1);
    if (state_d == SET && state_q == SET) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_d     = blink_q;
      end
    end
  end

  assign disp = (state_q == SET) ? preset_q : count_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd (disp[4*g +: 4]),
      .seg (dec_raw[7*g +: 7])
    );
  end

  always_comb begin
    seg_d = dec_raw;
    for (int i = 0; i < DIGITS; i++) begin
      if (state_q == SET && blink_q && cursor_q == CW'(i)) seg_d[7*i +: 7] = SEG_BLANK;
    end
    seg_d = seg_d ^ {SW{INV_BIT}};

    case (state_q)
      SW_STOP, SW_RUN:          led_mode_d = LED_STOPWATCH;
      TM_STOP, TM_RUN, TM_DONE: led_mode_d = LED_TIMER;
      default:                  led_mode_d = LED_SET;
    endcase
    led_run_d  = in_run;
    led_done_d = (state_q == TM_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SW_STOP;
      count_q     <= '0;
      preset_q    <= '0;
      cursor_q    <= '0;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      seg_q       <= SEG_RST;
      led_mode_q  <= LED_STOPWATCH;
      led_run_q   <= 1'b0;
      led_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      preset_q    <= preset_d;
      cursor_q    <= cursor_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      seg_q       <= seg_d;
      led_mode_q  <= led_mode_d;
      led_run_q   <= led_run_d;
      led_done_q  <= led_done_d;
    end
  end

  assign seg      = seg_q;
  assign led_mode = led_mode_q;
  assign led_run  = led_run_q;
  assign led_done = led_done_q;

endmodule

// File: tb/tb_multi_mode_timer.sv
// Directed bench for multi_mode_timer with DIGITS=2, TICK_DIV=4, BLINK_DIV=3.
module tb_multi_mode_timer;

  localparam int DIGITS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  btn = '0;   // {down, up, set, start, mode}
  logic [13:0] seg;
  logic [2:0]  led_mode;
  logic        led_run;
  logic        led_done;

  int n_checks = 0;
  int n_errors = 0;

  multi_mode_timer #(
    .DIGITS    (DIGITS),
    .TICK_DIV  (4),
    .BLINK_DIV (3),
    .SEG_INV   (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_btn  (btn[0]),
    .start_btn (btn[1]),
    .set_btn   (btn[2]),
    .up_btn    (btn[3]),
    .down_btn  (btn[4]),
    .seg       (seg),
    .led_mode  (led_mode),
    .led_run   (led_run),
    .led_done  (led_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] exp_seg(input int val);
    return {seg_of((val / 10) % 10), seg_of(val % 10)};
  endfunction

  function automatic logic [13:0] exp_blank(input int val, input int cur);
    logic [13:0] s;
    s = exp_seg(val);
    if (cur == 0) s[6:0] = 7'h00;
    else          s[13:7] = 7'h00;
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input int b);
    @(negedge clk);
    btn[b] = 1'b1;
    repeat (5) @(negedge clk);
    btn[b] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Holds start until led_run rises; returns at the first negedge showing it
  task automatic start_until_run(input string tag);
    int i;
    @(negedge clk);
    btn[1] = 1'b1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (led_run === 1'b1) break;
    end
    btn[1] = 1'b0;
    check(tag, {31'd0, led_run}, 32'd1);
  endtask

  task automatic check_set(input string tag, input int val, input int cur);
    int full, blank;
    full = 0;
    blank = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (seg === exp_seg(val)) full++;
      else if (seg === exp_blank(val, cur)) blank++;
    end
    check({tag, "_shown"}, full, 3);
    check({tag, "_blank"}, blank, 3);
  endtask

  initial begin
    int i;

    // Reset state and stopwatch basic run/stop/clear
    do_reset();
    check("rst_led_mode", {29'd0, led_mode}, 32'h1);
    check("rst_led_run", {31'd0, led_run}, 32'd0);
    check("rst_led_done", {31'd0, led_done}, 32'd0);
    check("rst_seg", {18'd0, seg}, {18'd0, exp_seg(0)});
    start_until_run("sw_run_start");
    repeat (40) @(negedge clk);
    check("sw_10_ticks", {18'd0, seg}, {18'd0, exp_seg(10)});
    press(1);
    check("sw_stop_run", {31'd0, led_run}, 32'd0);
    check("sw_stop_mode", {29'd0, led_mode}, 32'h1);
    press(4);
    check("sw_clear", {18'd0, seg}, {18'd0, exp_seg(0)});

    // Stopwatch wrap 98 -> 99 -> 00
    do_reset();
    start_until_run("wrap_start");
    for (i = 0; i < 600; i++) begin
      if (seg === exp_seg(98)) break;
      @(negedge clk);
    end
    check("wrap_reach_98", {18'd0, seg}, {18'd0, exp_seg(98)});
    repeat (4) @(negedge clk);
    check("wrap_99", {18'd0, seg}, {18'd0, exp_seg(99)});
    repeat (4) @(negedge clk);
    check("wrap_00", {18'd0, seg}, {18'd0, exp_seg(0)});
    check("wrap_no_done", {31'd0, led_done}, 32'd0);

    // Timer: preset 13, countdown to done, restart
    do_reset();
    press(0);
    check("tm_mode_timer", {29'd0, led_mode}, 32'h2);
    press(0);
    check("tm_mode_set", {29'd0, led_mode}, 32'h4);
    press(3); press(3); press(3);
    press(2);
    press(3);
    check_set("preset13", 13, 1);
    press(0);
    check("set_to_sw", {29'd0, led_mode}, 32'h1);
    press(0);
    check("tm_load_mode", {29'd0, led_mode}, 32'h2);
    check("tm_load_13", {18'd0, seg}, {18'd0, exp_seg(13)});
    start_until_run("tm_start");
    repeat (51) @(negedge clk);
    check("tm_not_done_yet", {31'd0, led_done}, 32'd0);
    @(negedge clk);
    check("tm_done", {31'd0, led_done}, 32'd1);
    check("tm_done_run", {31'd0, led_run}, 32'd0);
    check("tm_done_seg", {18'd0, seg}, {18'd0, exp_seg(0)});
    press(1);
    check("tm_back_done", {31'd0, led_done}, 32'd0);
    check("tm_back_mode", {29'd0, led_mode}, 32'h2);
    check("tm_back_seg", {18'd0, seg}, {18'd0, exp_seg(13)});

    // SET digit wrap, cursor wrap and blinking
    do_reset();
    press(0); press(0);
    press(4);
    check_set("set_down_wrap", 9, 0);
    press(2);
    check_set("set_cursor1", 9, 1);
    press(2);
    press(4);
    check_set("set_cursor_wrap", 8, 0);

    // Priority: mode beats start; start ignored with zero count; mode ignored while running
    do_reset();
    @(negedge clk);
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    repeat (5) @(negedge clk);
    btn = '0;
    repeat (6) @(negedge clk);
    check("prio_mode", {29'd0, led_mode}, 32'h2);
    check("prio_no_run", {31'd0, led_run}, 32'd0);
    press(1);
    check("tm_zero_start", {31'd0, led_run}, 32'd0);
    do_reset();
    start_until_run("ign_start");
    press(0);
    check("ign_mode_led", {29'd0, led_mode}, 32'h1);
    check("ign_mode_run", {31'd0, led_run}, 32'd1);

    // Reset during timer run
    do_reset();
    press(0); press(0);
    for (int k = 0; k < 5; k++) press(3);
    press(0); press(0);
    check("rr_load_05", {18'd0, seg}, {18'd0, exp_seg(5)});
    start_until_run("rr_start");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rr_mode", {29'd0, led_mode}, 32'h1);
    check("rr_run", {31'd0, led_run}, 32'd0);
    check("rr_seg", {18'd0, seg}, {18'd0, exp_seg(0)});
    reset = 1'b0;
    @(negedge clk);
    press(0); press(0);
    check_set("rr_preset", 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
